ppu_vram_access: RTL
====================

# ppu_vram_access

Downstream stage of the PPU DATA register (0x2007). Consumes the one-cycle write-complete pulse and latched byte from the DATA register, plus CPU read strobes for 0x2007. Performs the VRAM bus transaction and maintains the 14-bit VRAM address, incrementing it by 1 or 32 after every access. Owns the NES-style buffered read: non-palette reads return the previous buffer contents; palette reads (0x3F00–0x3FFF) return data immediately.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width
- PAL_BASE, 14'h3F00, first palette address (immediate-read region up to 0x3FFF)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- addr_load  in  1  one-cycle pulse: load addr_in (second 0x2006 write done)
- addr_in  in  14  new VRAM address
- inc_32  in  1  PPUCTRL bit 2; 0 = increment by 1, 1 = increment by 32
- wr_req  in  1  one-cycle pulse from DATA register write-complete
- wr_data  in  8  byte from DATA register
- rd_req  in  1  one-cycle pulse: CPU read of 0x2007
- rd_data  out  8  byte returned to CPU
- rd_valid  out  1  one-cycle pulse: rd_data updated
- vram_addr  out  14  current VRAM address; bus address during a transaction
- vram_wdata  out  8  write data
- vram_we  out  1  write strobe, held until ack
- vram_re  out  1  read strobe, held until ack
- vram_rdata  in  8  read data, valid with vram_ack
- vram_ack  in  1  transaction complete; may arrive in the first strobe cycle or later
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky: a request was dropped; cleared only by reset

## Operation
- States: IDLE, WRITE, READ.
- IDLE, wr_req=1: latch wr_data into vram_wdata and go to WRITE. A simultaneous rd_req is dropped and sets overrun.
- IDLE, rd_req=1 (no wr_req): go to READ.
- IDLE, addr_load=1: vram_addr <= addr_in. If wr_req/rd_req fires in the same cycle, the transaction uses addr_in.
- WRITE: vram_we=1; vram_addr and vram_wdata held stable. On vram_ack: vram_we=0, address update, go to IDLE.
- READ: vram_re=1; address held stable. On vram_ack:
  - If vram_addr >= PAL_BASE: rd_data <= vram_rdata.
  - Otherwise: rd_data <= buffer.
  - In both cases buffer <= vram_rdata, rd_valid pulses, address update, go to IDLE.
- Address update on completion:
  - If an addr_load is pending: vram_addr <= pending address. The increment is discarded.
  - Otherwise: vram_addr <= vram_addr + (inc_32 ? 32 : 1), modulo 2^14.
  - inc_32 is sampled in the ack cycle.
- addr_load while busy: capture addr_in into the pending register; do not disturb the bus address. A later load overwrites an earlier one. The pending register is cleared on completion.
- wr_req or rd_req while busy: dropped, overrun <= 1.
- Wrap-around examples:
  - 0x3FFF + 1 -> 0x0000.
  - 0x3FF0 + 32 -> 0x0010.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE; all outputs 0: vram_addr, vram_wdata, vram_we, vram_re, rd_data, rd_valid, busy, overrun.
  - Internal: buffer = 0x00; pending load cleared.
- Reset asserted mid-transaction aborts it. Strobes drop asynchronously; no address increment occurs.
- Request at edge N (IDLE): strobe and busy high from N+1.
- Ack sampled high at edge M: strobe low, busy low, vram_addr updated, rd_valid high (reads), all from M+1. rd_valid lasts exactly one cycle.
- Minimum transaction (ack in first strobe cycle): 2 cycles from request to IDLE. A new request is accepted in the cycle busy is low, i.e. back-to-back requests spaced 2 cycles apart with immediate ack are all serviced.
- vram_ack while IDLE is ignored.

## Test plan
- Reset, then addr_load 0x2000, inc_32=0, wr_req data 0xA5, ack after 2 cycles -> vram_we for 3 cycles at 0x2000/0xA5, then vram_addr=0x2001, busy=0.
- addr 0x2400, two rd_req with memory returning 0x11 then 0x22 -> rd_data 0x00 then 0x11; vram_addr ends 0x2402.
- addr 0x3F05, rd_req, memory returns 0x0C -> rd_data=0x0C immediately; vram_addr 0x3F06.
- inc_32=1 at addr 0x3FF0, write -> vram_addr 0x0010. inc_32=0 at 0x3FFF -> 0x0000.
- addr_load 0x1234 during a WRITE to 0x0100 -> bus address stays 0x0100 until ack, then vram_addr=0x1234 (no increment).
- wr_req while busy, and wr_req+rd_req together in IDLE -> overrun=1 and stays 1; only the write executes. Reset mid-READ -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/ppu_vram_access.sv
// VRAM access stage behind the PPU DATA register: runs one bus transaction per
// CPU request, auto-increments the VRAM address and implements the buffered read.
module ppu_vram_access #(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] PAL_BASE = 14'h3F00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              inc_32,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    input  logic              rd_req,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_re,
    input  logic [7:0]        vram_rdata,
    input  logic              vram_ack,
    output logic              busy,
    output logic              overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        buffer_q, buffer_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] step_amt;

    assign step_amt = inc_32 ? ADDR_W'(32) : ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        buffer_d     = buffer_q;
        overrun_d    = overrun_q;

        if (state_q == S_IDLE) begin
            // A same-cycle load takes effect before the transaction starts.
            if (addr_load) begin
                addr_d = addr_in;
            end
            if (wr_req) begin
                wdata_d = wr_data;
                state_d = S_WRITE;
                if (rd_req) begin
                    overrun_d = 1'b1;
                end
            end else if (rd_req) begin
                state_d = S_READ;
            end
        end else if (state_q == S_WRITE || state_q == S_READ) begin
            if (addr_load) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = addr_in;
            end
            if (wr_req || rd_req) begin
                overrun_d = 1'b1;
            end
            if (vram_ack) begin
                state_d      = S_IDLE;
                pend_valid_d = 1'b0;
                // A load arriving in the ack cycle counts as pending too.
                if (addr_load) begin
                    addr_d = addr_in;
                end else if (pend_valid_q) begin
                    addr_d = pend_addr_q;
                end else begin
                    addr_d = addr_q + step_amt;
                end
                if (state_q == S_READ) begin
                    rd_data_d  = (addr_q >= PAL_BASE) ? vram_rdata : buffer_q;
                    buffer_d   = vram_rdata;
                    rd_valid_d = 1'b1;
                end
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            wdata_q      <= 8'h00;
            rd_data_q    <= 8'h00;
            rd_valid_q   <= 1'b0;
            buffer_q     <= 8'h00;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            buffer_q     <= buffer_d;
            overrun_q    <= overrun_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign vram_we    = (state_q == S_WRITE);
    assign vram_re    = (state_q == S_READ);
    assign busy       = (state_q != S_IDLE);
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign overrun    = overrun_q;

endmodule
